skid_pipe_reg: RTL and testbench

//   Parametrised pipeline register with valid/ready handshake, 2-entry skid

---
 rtl/skid_pipe_reg_if.sv | 24 ++
 rtl/skid_pipe_reg.sv | 86 ++++++++
 tb/tb_skid_pipe_reg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/skid_pipe_reg_if.sv
// Handshake bundle for skid_pipe_reg: upstream D side, downstream Q side, flush and occupancy.
// The master drives the stimulus side. The slave is the register's own view.
interface skid_pipe_reg_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] D;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
    logic [1:0]       occupancy;

    modport master (
        output flush, in_valid, D, out_ready,
        input  in_ready, out_valid, Q, occupancy
    );

    modport slave (
        input  flush, in_valid, D, out_ready,
        output in_ready, out_valid, Q, occupancy
    );
endinterface

// File: rtl/skid_pipe_reg.sv
// Pipeline register with a 2-entry skid buffer, so it sustains one transfer per cycle under backpressure.
// Every output is a flop. Nothing passes combinationally from D or out_ready to any output.
module skid_pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst_n,
    skid_pipe_reg_if.slave bus
);
    // Handshake: a beat transfers on a rising edge where valid & ready are both high.
    // The sender holds its data stable while valid is high and ready is low.
    // The occupancy encoding doubles as the state, which makes it the visible FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= RESET_VAL;
            skid_q      <= RESET_VAL;
        end else if (bus.flush) begin
            // Drop every held entry. Leave the data flops untouched.
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        q_q         <= bus.D;
                        state       <= FULL;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        q_q <= bus.D;
                    end else if (in_fire) begin
                        skid_q     <= bus.D;
                        state      <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                SKID: begin
                    // in_ready is low here, so the only possible move is draining the head.
                    if (out_fire) begin
                        q_q        <= skid_q;
                        state      <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Q         = q_q;
    assign bus.occupancy = state;
endmodule

// File: tb/tb_skid_pipe_reg.sv
// Bench for skid_pipe_reg: directed table rows, hand-written reset and flush sequences, and a long random run.
// A queue of accepted data serves as the reference for ordering, occupancy and the handshake outputs.
module tb_skid_pipe_reg;
    localparam int          W  = 32;
    localparam logic [W-1:0] RV = 32'h0BAD_F00D;

    typedef struct {
        logic         flush;
        logic         in_valid;
        logic         out_ready;
        logic [W-1:0] d;
        logic [1:0]   exp_occ;
        logic         exp_in_ready;
        logic         exp_out_valid;
        logic [W-1:0] exp_q;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] exp_q[$];
    vec_t         vecs[17];

    skid_pipe_reg_if #(.WIDTH(W)) bus ();

    skid_pipe_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy, input logic [W-1:0] d);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.D         = d;
    endtask

    // One clock with the current inputs. The reference queue steps alongside the DUT.
    task automatic cycle();
        logic         in_f;
        logic         out_f;
        logic [W-1:0] d;
        logic         fl;
        logic         rs;
        in_f = bus.in_valid && (exp_q.size() < 2);
        out_f = bus.out_ready && (exp_q.size() > 0);
        d = bus.D;
        fl = bus.flush;
        rs = rst_n;
        if (out_f && rs) check("pop_order", bus.Q, exp_q[0]);
        @(posedge clk);
        #1;
        if (!rs) begin
            exp_q.delete();
            check("reset_q", bus.Q, RV);
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (out_f) void'(exp_q.pop_front());
            if (in_f) exp_q.push_back(d);
        end
        check("occupancy", W'(bus.occupancy), W'(exp_q.size()));
        check("in_ready", W'(bus.in_ready), W'(exp_q.size() < 2));
        check("out_valid", W'(bus.out_valid), W'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("head_q", bus.Q, exp_q[0]);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h1, 2'd1, 1'b1, 1'b1, 32'h1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h2, 2'd1, 1'b1, 1'b1, 32'h2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h3, 2'd1, 1'b1, 1'b1, 32'h3};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b1, 1'b0, 32'h3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'hA, 2'd1, 1'b1, 1'b1, 32'hA};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'hB, 2'd2, 1'b0, 1'b1, 32'hA};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'hC, 2'd2, 1'b0, 1'b1, 32'hA};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'hC, 2'd1, 1'b1, 1'b1, 32'hB};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hC, 2'd1, 1'b1, 1'b1, 32'hC};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b1, 1'b0, 32'hC};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h5, 2'd1, 1'b1, 1'b1, 32'h5};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h6, 2'd2, 1'b0, 1'b1, 32'h5};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h7, 2'd0, 1'b1, 1'b0, 32'h5};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b1, 1'b0, 32'h5};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h8, 2'd1, 1'b1, 1'b1, 32'h8};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h9, 2'd0, 1'b1, 1'b0, 32'h8};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b1, 1'b0, 32'h8};

        // reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        cycle();
        cycle();
        rst_n = 1'b1;
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_occ", W'(bus.occupancy), '0);

        // directed table: streaming, skid fill and drain, flush from SKID and FULL
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].d);
            cycle();
            check($sformatf("vec%0d_occ", i), W'(bus.occupancy), W'(vecs[i].exp_occ));
            check($sformatf("vec%0d_in_ready", i), W'(bus.in_ready), W'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_out_valid", i), W'(bus.out_valid), W'(vecs[i].exp_out_valid));
            check($sformatf("vec%0d_q", i), bus.Q, vecs[i].exp_q);
        end

        // reset while holding one entry, with a valid beat offered
        drive(1'b0, 1'b1, 1'b0, 32'h9);
        cycle();
        check("pre_rst_q", bus.Q, 32'h9);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h11);
        cycle();
        check("rst_mid_occ", W'(bus.occupancy), '0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, '0);
        cycle();
        check("post_rst_q", bus.Q, RV);

        // reset while the skid buffer is full
        drive(1'b0, 1'b1, 1'b0, 32'h21);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h22);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, '0);
        cycle();

        // random traffic with occasional flush, plus a hold check on Q under stall
        for (int i = 0; i < 2000; i++) begin
            logic         stalled;
            logic [W-1:0] prev_q;
            stalled = bus.out_valid && !bus.out_ready && !bus.flush;
            prev_q = bus.Q;
            if (i > 0 && stalled) begin
                cycle();
                check("stall_hold_q", bus.Q, prev_q);
                check("stall_hold_valid", W'(bus.out_valid), W'(1));
            end
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom);
            cycle();
        end

        // drain
        drive(1'b0, 1'b0, 1'b1, '0);
        cycle();
        cycle();
        check("drained", W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
